// File: rtl/sat_sub_serial_pkg.sv
// sat_sub_serial_pkg: shared ALU constants, state encoding and flag-register bit positions
package sat_sub_serial_pkg;
    localparam int ALU_WIDTH = 16;
    localparam int ALU_SLICE = 4;
    localparam int ALU_NSLICE = ALU_WIDTH / ALU_SLICE;
    localparam logic [ALU_WIDTH-1:0] SAT_POS = 16'h7FFF;
    localparam logic [ALU_WIDTH-1:0] SAT_NEG = 16'h8000;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/sat_sub_serial_if.sv
// sat_sub_serial_if: start/done request bus between the ALU and the serial saturating subtractor
interface sat_sub_serial_if
    import sat_sub_serial_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) ();
    logic start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic busy;
    logic done;
    logic [WIDTH-1:0] diff;
    logic flag_z;
    logic flag_v;
    logic flag_n;
    modport master (
        output start, a, b,
        input  busy, done, diff, flag_z, flag_v, flag_n
    );
    modport slave (
        input  start, a, b,
        output busy, done, diff, flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/sat_sub_serial_sub_slice.sv
// sub_slice: combinational slice adder; nb is the already-inverted subtrahend slice
module sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] nb,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, nb} + {{SLICE{1'b0}}, cin};
endmodule

// File: rtl/sat_sub_serial.sv
// sat_sub_serial: multi-cycle saturating A - B, one slice per cycle through a shared slice adder
module sat_sub_serial
    import sat_sub_serial_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SLICE = ALU_SLICE
) (
    input logic clk,
    input logic rst_n,
    sat_sub_serial_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = $clog2(NSLICE);
    localparam logic [IW:0] LAST = NSLICE[IW:0];

    state_t state;
    logic [IW:0] cnt;
    logic carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] diff;
    logic [2:0] flags;
    logic busy;
    logic done;
    logic [IW-1:0] idx;
    logic [SLICE-1:0] s_sum;
    logic s_cout;
    logic ovf;
    logic [WIDTH-1:0] res;

    assign idx = cnt[IW-1:0];

    sub_slice #(.SLICE(SLICE)) u_slice (
        .a   (a_q[idx*SLICE +: SLICE]),
        .nb  (nb_q[idx*SLICE +: SLICE]),
        .cin (carry),
        .s   (s_sum),
        .cout(s_cout)
    );

    // saturate the raw difference; nb_q holds ~b, so equal MSBs mean the operand signs differ
    always_comb begin
        ovf = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (part[WIDTH-1] != a_q[WIDTH-1]);
        res = ovf ? (a_q[WIDTH-1] ? SAT_NEG : SAT_POS) : part;
    end

    // sequencer: accept, ripple slices through the carry register, then publish for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            nb_q  <= '0;
            part  <= '0;
            diff  <= '0;
            flags <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_q   <= bus.a;
                    nb_q  <= ~bus.b;
                    carry <= 1'b1;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= CALC;
                end
                CALC: if (cnt == LAST) begin
                    diff          <= res;
                    flags[FLAG_Z] <= (res == '0);
                    flags[FLAG_V] <= ovf;
                    flags[FLAG_N] <= res[WIDTH-1];
                    done          <= 1'b1;
                    state         <= DONE;
                end else begin
                    part[idx*SLICE +: SLICE] <= s_sum;
                    carry <= s_cout;
                    cnt   <= cnt + 1'b1;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.diff   = diff;
    assign bus.flag_z = flags[FLAG_Z];
    assign bus.flag_v = flags[FLAG_V];
    assign bus.flag_n = flags[FLAG_N];
endmodule
